sig_mul_iter: RTL and testbench

Parametrised, multi-cycle successor to the combinational significand datapath of the FP multiplier. It multiplies two (MAN_W+1)-bit significands, with hidden bits derived from the zero-exponent flags, using an iterative radix-2^BPC shift-add array. It then normalises, computes guard and sticky bits, and rounds in all four IEEE modes. It sits between exponent/sign logic and the result packer, using valid/ready handshakes on both sides so it can serve single (MAN_W=23) or double (MAN_W=52) precision.

---
 rtl/fpu_sig_pkg.sv | 21 ++
 rtl/sig_round_norm.sv | 76 +++++++
 rtl/sig_mul_iter.sv | 161 ++++++++++++++++
 tb/tb_sig_mul_iter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fpu_sig_pkg.sv
// Shared types and helpers for the FP significand datapaths (multiplier, later divider).
package fpu_sig_pkg;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;
  localparam logic [1:0] RM_RDN = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_RND, ST_DONE} sig_state_e;

  typedef struct packed {
    logic [1:0] rm;
    logic       sz;
  } sig_rnd_ctl_t;

  // Number of shift-add iterations needed to consume the whole significand.
  function automatic int sig_iter(input int man_w, input int bpc);
    return (man_w + 1) / bpc;
  endfunction

endpackage

// File: rtl/sig_round_norm.sv
// Combinational normalise / guard+sticky / IEEE round of a 2*SW-bit significand product.
// SIG_MUL_INEXACT_EN adds the inexact (G|T) output.
module sig_round_norm
  import fpu_sig_pkg::*;
#(
  parameter int MAN_W = 23,
  parameter int SW    = MAN_W + 1,
  parameter int SHL_W = $clog2(2 * SW)
) (
  input  logic [2*SW-1:0]  prod,
  input  logic [1:0]       rm,
  input  logic             sz,
  output logic [SW-1:0]    mz,
  output logic             ovf,
  output logic [SHL_W-1:0] shl,
  output logic             ovf_rnd
`ifdef SIG_MUL_INEXACT_EN
  ,
  output logic             inexact
`endif
);

  localparam int PW = 2 * SW;

  logic [SHL_W-1:0] lzc;
  logic [PW-2:0]    pn;
  logic [SW-1:0]    kept;
  logic             g, t, up;
  logic [SW:0]      sum;

  // Leading-zero count over P[PW-2:0]; the highest set bit wins.
  always_comb begin
    lzc = '0;
    for (int i = 0; i < PW - 1; i++)
      if (prod[i]) lzc = SHL_W'(PW - 2 - i);
  end

  always_comb begin
    pn   = '0;
    kept = '0;
    g    = 1'b0;
    t    = 1'b0;
    ovf  = 1'b0;
    shl  = '0;
    if (prod[PW-1]) begin
      ovf  = 1'b1;
      kept = prod[PW-1:SW];
      g    = prod[SW-1];
      t    = |prod[SW-2:0];
    end else if (prod != '0) begin
      shl  = lzc;
      pn   = prod[PW-2:0] << lzc;
      kept = pn[PW-2:SW-1];
      g    = pn[SW-2];
      t    = |pn[SW-3:0];
    end
  end

  always_comb begin
    up = 1'b0;
    unique case (rm)
      RM_RNE:  up = g & (t | kept[0]);
      RM_RTZ:  up = 1'b0;
      RM_RUP:  up = ~sz & (g | t);
      default: up = sz & (g | t);
    endcase
    sum     = {1'b0, kept} + {{SW{1'b0}}, up};
    ovf_rnd = sum[SW];
    mz      = sum[SW] ? {1'b1, {MAN_W{1'b0}}} : sum[SW-1:0];
  end

`ifdef SIG_MUL_INEXACT_EN
  assign inexact = g | t;
`endif

endmodule

// File: rtl/sig_mul_iter.sv
// Iterative radix-2^BPC significand multiplier with normalise and IEEE rounding, valid/ready on both sides.
// SIG_MUL_INEXACT_EN adds a registered inexact output.
module sig_mul_iter
  import fpu_sig_pkg::*;
#(
  parameter int MAN_W = 23,
  parameter int BPC   = 4,
  parameter int SHL_W = $clog2(2 * (MAN_W + 1))
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAN_W-1:0] Mx,
  input  logic [MAN_W-1:0] My,
  input  logic             zero_Ex,
  input  logic             zero_Ey,
  input  logic [1:0]       R_mode,
  input  logic             Sz,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAN_W:0]   Mz,
  output logic             ovf,
  output logic [SHL_W-1:0] SHL,
  output logic             Overflow_after_round
`ifdef SIG_MUL_INEXACT_EN
  ,
  output logic             inexact
`endif
);

  localparam int SW   = MAN_W + 1;
  localparam int PW   = 2 * SW;
  localparam int ITER = sig_iter(MAN_W, BPC);
  localparam int CW   = $clog2(ITER + 1);

  if (SW % BPC != 0) begin : g_bad_bpc
    $error("sig_mul_iter: significand width must be a multiple of BPC");
  end

  sig_state_e       state_q, state_d;
  logic [SW-1:0]    a_q, a_d, b_q, b_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  sig_rnd_ctl_t     ctl_q, ctl_d;
  logic [SW-1:0]    mz_q, mz_d;
  logic             ovf_q, ovf_d, ora_q, ora_d;
  logic [SHL_W-1:0] shl_q, shl_d;
  logic [SW+BPC-1:0] pp;

  logic [SW-1:0]    rn_mz;
  logic             rn_ovf, rn_ora;
  logic [SHL_W-1:0] rn_shl;
`ifdef SIG_MUL_INEXACT_EN
  logic             rn_inx, inx_q, inx_d;
`endif

  sig_round_norm #(.MAN_W(MAN_W), .SW(SW), .SHL_W(SHL_W)) u_rnd (
    .prod    (acc_q),
    .rm      (ctl_q.rm),
    .sz      (ctl_q.sz),
    .mz      (rn_mz),
    .ovf     (rn_ovf),
    .shl     (rn_shl),
    .ovf_rnd (rn_ora)
`ifdef SIG_MUL_INEXACT_EN
    ,
    .inexact (rn_inx)
`endif
  );

  // One radix-2^BPC digit of B per cycle, LSB digit first.
  assign pp = {{BPC{1'b0}}, a_q} * {{SW{1'b0}}, b_q[BPC-1:0]};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ctl_d   = ctl_q;
    mz_d    = mz_q;
    ovf_d   = ovf_q;
    shl_d   = shl_q;
    ora_d   = ora_q;
`ifdef SIG_MUL_INEXACT_EN
    inx_d   = inx_q;
`endif
    unique case (state_q)
      ST_IDLE: if (in_valid) begin
        a_d     = {~zero_Ex, Mx};
        b_d     = {~zero_Ey, My};
        ctl_d   = '{rm: R_mode, sz: Sz};
        acc_d   = '0;
        cnt_d   = '0;
        state_d = ST_MUL;
      end
      ST_MUL: begin
        acc_d = acc_q + (PW'(pp) << (cnt_q * BPC));
        b_d   = b_q >> BPC;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ITER - 1)) state_d = ST_RND;
      end
      ST_RND: begin
        mz_d    = rn_mz;
        ovf_d   = rn_ovf;
        shl_d   = rn_shl;
        ora_d   = rn_ora;
`ifdef SIG_MUL_INEXACT_EN
        inx_d   = rn_inx;
`endif
        state_d = ST_DONE;
      end
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ctl_q   <= '0;
      mz_q    <= '0;
      ovf_q   <= 1'b0;
      shl_q   <= '0;
      ora_q   <= 1'b0;
`ifdef SIG_MUL_INEXACT_EN
      inx_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ctl_q   <= ctl_d;
      mz_q    <= mz_d;
      ovf_q   <= ovf_d;
      shl_q   <= shl_d;
      ora_q   <= ora_d;
`ifdef SIG_MUL_INEXACT_EN
      inx_q   <= inx_d;
`endif
    end
  end

  assign in_ready             = (state_q == ST_IDLE);
  assign out_valid            = (state_q == ST_DONE);
  assign Mz                   = mz_q;
  assign ovf                  = ovf_q;
  assign SHL                  = shl_q;
  assign Overflow_after_round = ora_q;
`ifdef SIG_MUL_INEXACT_EN
  assign inexact              = inx_q;
`endif

endmodule

// File: tb/tb_sig_mul_iter.sv
// Randomised + directed bench for sig_mul_iter against an integer-arithmetic rounding model.
module tb_sig_mul_iter;

  localparam int MAN_W = 23;
  localparam int SW    = MAN_W + 1;
  localparam int SHL_W = $clog2(2 * SW);
  localparam int ITER  = SW / 4;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [MAN_W-1:0] Mx = '0;
  logic [MAN_W-1:0] My = '0;
  logic             zero_Ex = 1'b0;
  logic             zero_Ey = 1'b0;
  logic [1:0]       R_mode = 2'b00;
  logic             Sz = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [SW-1:0]    Mz;
  logic             ovf;
  logic [SHL_W-1:0] SHL;
  logic             Overflow_after_round;
`ifdef SIG_MUL_INEXACT_EN
  logic             inexact;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  sig_mul_iter dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .Mx(Mx), .My(My), .zero_Ex(zero_Ex), .zero_Ey(zero_Ey),
    .R_mode(R_mode), .Sz(Sz), .out_valid(out_valid), .out_ready(out_ready),
    .Mz(Mz), .ovf(ovf), .SHL(SHL), .Overflow_after_round(Overflow_after_round)
`ifdef SIG_MUL_INEXACT_EN
    , .inexact(inexact)
`endif
  );

  typedef struct {
    logic [SW-1:0]    mz;
    logic             ovf;
    logic [SHL_W-1:0] shl;
    logic             ora;
    logic             inx;
  } exp_t;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer product, locate its MSB, take 24 bits from there, round.
  function automatic exp_t model(input logic [MAN_W-1:0] mx, input logic [MAN_W-1:0] my,
                                 input logic zx, input logic zy, input logic [1:0] rm, input logic sz);
    longint unsigned a, b, p, kept, rem, half;
    int   msb;
    logic g, t, up;
    exp_t e;
    a = (zx ? 64'd0 : 64'h800000) + 64'(mx);
    b = (zy ? 64'd0 : 64'h800000) + 64'(my);
    p = a * b;
    e.mz = '0; e.ovf = 1'b0; e.shl = '0; e.ora = 1'b0; e.inx = 1'b0;
    if (p == 0) return e;
    msb = 0;
    for (int k = 0; k < 48; k++) if ((p >> k) != 0) msb = k;
    g = 1'b0;
    t = 1'b0;
    if (msb >= 23) begin
      kept = p >> (msb - 23);
      rem  = p - (kept << (msb - 23));
    end else begin
      kept = p << (23 - msb);
      rem  = 0;
    end
    if (msb >= 24) begin
      half = 64'd1 << (msb - 24);
      g    = (rem >= half);
      t    = (rem % half) != 0;
    end
    e.ovf = (msb == 47);
    e.shl = (msb == 47) ? SHL_W'(0) : SHL_W'(46 - msb);
    case (rm)
      2'b00:   up = g & (t | kept[0]);
      2'b01:   up = 1'b0;
      2'b10:   up = !sz && (g || t);
      default: up = sz && (g || t);
    endcase
    kept = kept + (up ? 64'd1 : 64'd0);
    if (kept == 64'h1000000) begin
      e.mz  = 24'h800000;
      e.ora = 1'b1;
    end else begin
      e.mz = kept[SW-1:0];
    end
    e.inx = g | t;
    return e;
  endfunction

  task automatic run_op(input logic [MAN_W-1:0] mx, input logic [MAN_W-1:0] my,
                        input logic zx, input logic zy, input logic [1:0] rm,
                        input logic sz, input int hold);
    exp_t e;
    int   lat;
    e = model(mx, my, zx, zy, rm, sz);
    Mx = mx; My = my; zero_Ex = zx; zero_Ey = zy; R_mode = rm; Sz = sz;
    in_valid = 1'b1;
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    @(posedge CLK); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge CLK); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(ITER + 1));
    chk("Mz", 64'(Mz), 64'(e.mz));
    chk("ovf", 64'(ovf), 64'(e.ovf));
    chk("SHL", 64'(SHL), 64'(e.shl));
    chk("ovf_after_round", 64'(Overflow_after_round), 64'(e.ora));
`ifdef SIG_MUL_INEXACT_EN
    chk("inexact", 64'(inexact), 64'(e.inx));
`endif
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      Mx = ~mx; My = ~my; zero_Ex = ~zx; R_mode = ~rm;
      @(posedge CLK); #1;
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_Mz_stable", 64'(Mz), 64'(e.mz));
      chk("bp_SHL_stable", 64'(SHL), 64'(e.shl));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
    chk("hs_out_valid", 64'(out_valid), 64'd0);
    chk("hs_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_Mz", 64'(Mz), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_SHL", 64'(SHL), 64'd0);
    chk("rst_ora", 64'(Overflow_after_round), 64'd0);
    RST = 1'b1;
    @(posedge CLK); #1;

    run_op(23'h000000, 23'h000000, 1'b0, 1'b0, 2'b00, 1'b0, 0);
    run_op(23'h400000, 23'h400000, 1'b0, 1'b0, 2'b00, 1'b0, 0);
    for (int rm = 0; rm < 4; rm++)
      run_op(23'h7FFFFF, 23'h000001, 1'b0, 1'b0, 2'(rm), 1'b0, 0);
    run_op(23'h7FFFFF, 23'h7FFFFF, 1'b0, 1'b0, 2'b10, 1'b0, 0);
    run_op(23'h400000, 23'h000000, 1'b1, 1'b0, 2'b00, 1'b0, 0);
    // 8191*8193 = 2^26-1: all-ones kept with G=1, rounding carries out
    run_op(23'h001FFF, 23'h002001, 1'b1, 1'b1, 2'b00, 1'b0, 0);
    run_op(23'h001FFF, 23'h002001, 1'b1, 1'b1, 2'b11, 1'b1, 0);
    run_op(23'h001FFF, 23'h002001, 1'b1, 1'b1, 2'b01, 1'b0, 0);
    run_op(23'h000000, 23'h123456, 1'b1, 1'b0, 2'b00, 1'b0, 0);
    run_op(23'h123456, 23'h654321, 1'b0, 1'b0, 2'b00, 1'b0, 5);

    // Reset during MUL abandons the operation
    Mx = 23'h3ABCDE; My = 23'h155555; zero_Ex = 1'b0; zero_Ey = 1'b0;
    in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge CLK);
    #2;
    RST = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_Mz", 64'(Mz), 64'd0);
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      chk("abandoned_no_out", 64'(out_valid), 64'd0);
    end
    run_op(23'h3ABCDE, 23'h155555, 1'b0, 1'b0, 2'b00, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      run_op(23'($urandom), 23'($urandom),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 7) == 0) ? 3 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
